// File: rtl/magnetron_timer_if.sv
// Signal bundle between the control/keypad logic (master) and the magnetron timer (slave).
// key_valid is a one-cycle strobe qualifying key_digit; there is no ready: the timer samples
// the digit on the edge key_valid is high and silently drops it when it cannot accept it.
interface magnetron_timer_if;
    logic       Set;
    logic       Reset;
    logic       limpaN;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       tdone;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       beep;
    logic [1:0] state_dbg;

    modport master (
        output Set, Reset, limpaN, key_valid, key_digit,
        input  tdone, mag_on, min_tens, min_ones, sec_tens, sec_ones, beep, state_dbg
    );

    modport slave (
        input  Set, Reset, limpaN, key_valid, key_digit,
        output tdone, mag_on, min_tens, min_ones, sec_tens, sec_ones, beep, state_dbg
    );
endinterface

// File: rtl/magnetron_timer.sv
// Cooking countdown timer and magnetron enable latch with a 4-digit BCD time field.
// Optional expiry buzzer is built only when MAGNETRON_BEEP_EN is defined.
module magnetron_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int BEEP_SECS     = 3
) (
    input  logic               clk,
    input  logic               rst,
    magnetron_timer_if.slave   bus
);
    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 2 || BEEP_SECS < 1) begin : g_bad_params
        $error("magnetron_timer: TICKS_PER_SEC must be >= 2 and BEEP_SECS >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   digits;
    logic          mag_on_q;
    logic          tdone_q;
    logic          key_ok;
    logic          time_zero;
    logic          presc_last;
    logic [15:0]   digits_shift;
    logic [15:0]   digits_dec;

`ifdef MAGNETRON_BEEP_EN
    localparam int            BW        = $clog2(BEEP_SECS + 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECS - 1);
    logic          beep_q;
    logic [BW-1:0] beep_sec;
`endif

    assign key_ok       = bus.key_valid && (bus.key_digit <= 4'd9);
    assign time_zero    = (digits == 16'h0000);
    assign presc_last   = (presc == PRESC_LAST);
    assign digits_shift = {digits[11:0], bus.key_digit};

    // Seconds may hold 60..99; borrowing from them is a plain BCD decrement.
    always_comb begin
        digits_dec = digits;
        if (digits[3:0] != 4'd0) begin
            digits_dec[3:0] = digits[3:0] - 4'd1;
        end else if (digits[7:4] != 4'd0) begin
            digits_dec[7:4] = digits[7:4] - 4'd1;
            digits_dec[3:0] = 4'd9;
        end else begin
            digits_dec[7:0] = 8'h59;
            if (digits[11:8] != 4'd0) begin
                digits_dec[11:8] = digits[11:8] - 4'd1;
            end else begin
                digits_dec[11:8]  = 4'd9;
                digits_dec[15:12] = digits[15:12] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            digits   <= '0;
            presc    <= '0;
            mag_on_q <= 1'b0;
            tdone_q  <= 1'b0;
`ifdef MAGNETRON_BEEP_EN
            beep_q   <= 1'b0;
            beep_sec <= '0;
`endif
        end else if (!bus.limpaN) begin
            state    <= IDLE;
            digits   <= '0;
            mag_on_q <= 1'b0;
            tdone_q  <= 1'b0;
`ifdef MAGNETRON_BEEP_EN
            beep_q   <= 1'b0;
`endif
        end else if (bus.Reset) begin
            // Pause: digits are kept; an expired timer stays expired.
            if (state == RUN) begin
                state    <= IDLE;
                mag_on_q <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Set && !time_zero) begin
                        state    <= RUN;
                        presc    <= '0;
                        mag_on_q <= 1'b1;
                    end else if (key_ok) begin
                        digits <= digits_shift;
                    end
                end
                RUN: begin
                    if (presc_last) begin
                        presc  <= '0;
                        digits <= digits_dec;
                        if (digits_dec == 16'h0000) begin
                            state    <= DONE;
                            mag_on_q <= 1'b0;
                            tdone_q  <= 1'b1;
`ifdef MAGNETRON_BEEP_EN
                            beep_q   <= 1'b1;
                            beep_sec <= '0;
`endif
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DONE: begin
                    if (key_ok) begin
                        digits  <= digits_shift;
                        state   <= IDLE;
                        tdone_q <= 1'b0;
`ifdef MAGNETRON_BEEP_EN
                        beep_q  <= 1'b0;
`endif
                    end
`ifdef MAGNETRON_BEEP_EN
                    // The idle prescaler times the buzzer in whole seconds.
                    else if (beep_q) begin
                        if (presc_last) begin
                            presc <= '0;
                            if (beep_sec == BEEP_LAST) beep_q <= 1'b0;
                            else                       beep_sec <= beep_sec + 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mag_on    = mag_on_q;
    assign bus.tdone     = tdone_q;
    assign bus.min_tens  = digits[15:12];
    assign bus.min_ones  = digits[11:8];
    assign bus.sec_tens  = digits[7:4];
    assign bus.sec_ones  = digits[3:0];
    assign bus.state_dbg = state;
`ifdef MAGNETRON_BEEP_EN
    assign bus.beep      = beep_q;
`else
    assign bus.beep      = 1'b0;
`endif
endmodule

// File: tb/tb_magnetron_timer.sv
// Directed and random checks of magnetron_timer against a seconds-level reference model.
module tb_magnetron_timer;
    localparam int TPS   = 4;
    localparam int BSECS = 3;
`ifdef MAGNETRON_BEEP_EN
    localparam bit BEEP_ON = 1'b1;
`else
    localparam bit BEEP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    magnetron_timer_if bus ();

    magnetron_timer #(.TICKS_PER_SEC(TPS), .BEEP_SECS(BSECS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: time as a 4-digit decimal number (mm*100 + ss).
    int m_n, m_phase, m_beep_left;
    bit m_run, m_done;

    function automatic logic [15:0] to_bcd(int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic m_reset();
        m_n = 0; m_phase = 0; m_beep_left = 0; m_run = 0; m_done = 0;
    endtask

    task automatic m_edge(bit s, bit r, bit l, bit kv, int kd);
        if (!l) begin
            m_n = 0; m_run = 0; m_done = 0; m_beep_left = 0;
        end else if (r) begin
            m_run = 0;
        end else if (m_run) begin
            m_phase++;
            if (m_phase == TPS) begin
                m_phase = 0;
                if (m_n % 100 > 0) m_n = m_n - 1;
                else               m_n = m_n - 100 + 59;
                if (m_n == 0) begin
                    m_run = 0; m_done = 1; m_beep_left = BSECS * TPS;
                end
            end
        end else if (m_done) begin
            if (kv && kd <= 9) begin
                m_n = (m_n * 10 + kd) % 10000; m_done = 0; m_beep_left = 0;
            end else if (m_beep_left > 0) begin
                m_beep_left--;
            end
        end else begin
            if (s && m_n != 0) begin
                m_run = 1; m_phase = 0;
            end else if (kv && kd <= 9) begin
                m_n = (m_n * 10 + kd) % 10000;
            end
        end
    endtask

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dut_time();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic check_model(string tag);
        check({tag, ".time"},   dut_time(),       to_bcd(m_n));
        check({tag, ".mag_on"}, 16'(bus.mag_on),  16'(m_run));
        check({tag, ".tdone"},  16'(bus.tdone),   16'(m_done));
        check({tag, ".beep"},   16'(bus.beep),    16'(BEEP_ON && m_beep_left > 0));
    endtask

    task automatic step(bit s, bit r, bit l, bit kv, int kd);
        bus.Set = s; bus.Reset = r; bus.limpaN = l; bus.key_valid = kv; bus.key_digit = 4'(kd);
        @(posedge clk);
        m_edge(s, r, l, kv, kd);
        #1 check_model("step");
        bus.Set = 1'b0; bus.Reset = 1'b0; bus.limpaN = 1'b1; bus.key_valid = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0);
    endtask

    task automatic key(int d);
        step(0, 0, 1, 1, d);
    endtask

    initial begin
        int bcnt;
        int r;
        bus.Set = 1'b0; bus.Reset = 1'b0; bus.limpaN = 1'b1;
        bus.key_valid = 1'b0; bus.key_digit = 4'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 check_model("reset");
        check("reset.state", 16'(bus.state_dbg), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // 00:10 runs to expiry in 40 cycles
        key(1); key(0);
        check("k10.time", dut_time(), 16'h0010);
        step(1, 0, 1, 0, 0);
        check("k10.mag_on", 16'(bus.mag_on), 16'd1);
        idle(39);
        check("k10.pre_time", dut_time(), 16'h0001);
        check("k10.pre_tdone", 16'(bus.tdone), 16'd0);
        idle(1);
        check("k10.done_time", dut_time(), 16'h0000);
        check("k10.done_tdone", 16'(bus.tdone), 16'd1);
        check("k10.done_mag", 16'(bus.mag_on), 16'd0);
        bcnt = int'(bus.beep);
        for (int i = 0; i < 13; i++) begin
            idle(1);
            bcnt += int'(bus.beep);
        end
        check("beep.len", 16'(bcnt), BEEP_ON ? 16'd12 : 16'd0);

        // DONE: Set ignored, key leaves
        step(1, 0, 1, 0, 0);
        check("done.set_tdone", 16'(bus.tdone), 16'd1);
        check("done.set_mag", 16'(bus.mag_on), 16'd0);
        key(5);
        check("done.key_tdone", 16'(bus.tdone), 16'd0);
        check("done.key_time", dut_time(), 16'h0005);

        // key during beep
        step(1, 0, 1, 0, 0);
        idle(20);
        check("beep2.tdone", 16'(bus.tdone), 16'd1);
        idle(2);
        check("beep2.on", 16'(bus.beep), 16'(BEEP_ON));
        key(3);
        check("beep2.key_off", 16'(bus.beep), 16'd0);
        check("beep2.time", dut_time(), 16'h0003);
        step(0, 0, 0, 0, 0);

        // limpaN mid-run at 02:15
        key(2); key(1); key(5);
        check("c215.time", dut_time(), 16'h0215);
        step(1, 0, 1, 0, 0);
        idle(6);
        step(0, 0, 0, 0, 0);
        check("c215.clr_time", dut_time(), 16'h0000);
        check("c215.clr_mag", 16'(bus.mag_on), 16'd0);
        check("c215.clr_state", 16'(bus.state_dbg), 16'd0);

        // minute borrows
        key(1); key(0); key(0);
        step(1, 0, 1, 0, 0);
        idle(4);
        check("m100.time", dut_time(), 16'h0059);
        step(0, 0, 0, 0, 0);
        key(1); key(0); key(0); key(0);
        step(1, 0, 1, 0, 0);
        idle(4);
        check("m1000.time", dut_time(), 16'h0959);
        step(0, 0, 0, 0, 0);

        // 00:90 is 90 seconds
        key(9); key(0);
        step(1, 0, 1, 0, 0);
        idle(359);
        check("s90.pre_time", dut_time(), 16'h0001);
        idle(1);
        check("s90.tdone", 16'(bus.tdone), 16'd1);
        step(0, 0, 0, 0, 0);

        // pause 2 cycles after a tick, resume with a fresh second
        key(5);
        step(1, 0, 1, 0, 0);
        idle(4);
        check("pause.tick", dut_time(), 16'h0004);
        idle(2);
        step(0, 1, 1, 0, 0);
        check("pause.mag", 16'(bus.mag_on), 16'd0);
        idle(3);
        check("pause.hold", dut_time(), 16'h0004);
        step(1, 0, 1, 0, 0);
        idle(3);
        check("resume.early", dut_time(), 16'h0004);
        idle(1);
        check("resume.tick", dut_time(), 16'h0003);
        step(0, 0, 0, 0, 0);

        // Set+Reset together, Set with zero time
        key(3); key(0);
        step(1, 1, 1, 0, 0);
        check("setrst.mag", 16'(bus.mag_on), 16'd0);
        idle(5);
        check("setrst.time", dut_time(), 16'h0030);
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        check("zero.mag", 16'(bus.mag_on), 16'd0);
        check("zero.state", 16'(bus.state_dbg), 16'd0);

        // asynchronous rst mid-run
        key(4); key(5);
        step(1, 0, 1, 0, 0);
        idle(5);
        #2 rst = 1'b1;
        #1 m_reset();
        check_model("arst");
        @(negedge clk);
        rst = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)       step(1, 0, 1, 0, 0);
            else if (r < 6)  step(0, 1, 1, 0, 0);
            else if (r < 7)  step(0, 0, 0, 0, 0);
            else if (r < 8)  step(1, 1, 1, 1, int'($urandom_range(0, 11)));
            else if (r < 12) key(int'($urandom_range(0, 11)));
            else             idle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
